// File: rtl/cc_speedtickgen_if.sv
// -----------------------------------------------------------------------------
// cc_speedtickgen_if
//
// Purpose:
//   Groups the control requests and status outputs of the speed tick generator
//   into one bundle. Clock and reset stay outside as plain module ports.
//
// Signals:
//   CC_SPEEDTICKGEN_enable_InHigh      run (1) / pause (0)
//   CC_SPEEDTICKGEN_levelup_InHigh     one-cycle level increment request
//   CC_SPEEDTICKGEN_levelclear_InHigh  one-cycle return-to-level-0 request
//   CC_SPEEDTICKGEN_T0_OutLow          registered tick, low for one cycle
//   CC_SPEEDTICKGEN_level_OutBUS       current speed level
//   CC_SPEEDTICKGEN_maxlevel_OutHigh   high while the level is saturated
//   CC_SPEEDTICKGEN_count_OutBUS       current counter value (debug/display)
//
// Modports:
//   master - game control / consumer side (drives requests, reads status)
//   slave  - the tick generator itself
// -----------------------------------------------------------------------------
interface cc_speedtickgen_if #(
  parameter int unsigned DATAWIDTH  = 23,
  parameter int unsigned LEVELWIDTH = 3
);

  logic                  CC_SPEEDTICKGEN_enable_InHigh;
  logic                  CC_SPEEDTICKGEN_levelup_InHigh;
  logic                  CC_SPEEDTICKGEN_levelclear_InHigh;
  logic                  CC_SPEEDTICKGEN_T0_OutLow;
  logic [LEVELWIDTH-1:0] CC_SPEEDTICKGEN_level_OutBUS;
  logic                  CC_SPEEDTICKGEN_maxlevel_OutHigh;
  logic [DATAWIDTH-1:0]  CC_SPEEDTICKGEN_count_OutBUS;

  modport master (
    output CC_SPEEDTICKGEN_enable_InHigh,
    output CC_SPEEDTICKGEN_levelup_InHigh,
    output CC_SPEEDTICKGEN_levelclear_InHigh,
    input  CC_SPEEDTICKGEN_T0_OutLow,
    input  CC_SPEEDTICKGEN_level_OutBUS,
    input  CC_SPEEDTICKGEN_maxlevel_OutHigh,
    input  CC_SPEEDTICKGEN_count_OutBUS
  );

  modport slave (
    input  CC_SPEEDTICKGEN_enable_InHigh,
    input  CC_SPEEDTICKGEN_levelup_InHigh,
    input  CC_SPEEDTICKGEN_levelclear_InHigh,
    output CC_SPEEDTICKGEN_T0_OutLow,
    output CC_SPEEDTICKGEN_level_OutBUS,
    output CC_SPEEDTICKGEN_maxlevel_OutHigh,
    output CC_SPEEDTICKGEN_count_OutBUS
  );

endinterface : cc_speedtickgen_if

// File: rtl/cc_speedtickgen.sv
// -----------------------------------------------------------------------------
// cc_speedtickgen
//
// Purpose:
//   Level-selectable speed tick generator for the game-object movement
//   pipeline. A free-running counter counts 0..TC and wraps; on the wrap it
//   emits a one-cycle active-low tick. TC = BASE - level*STEP, so the tick
//   period (TC+1 cycles) shortens as the level rises. Game control raises the
//   level one step at a time (saturating at MAXLEVEL) or clears it to 0.
//
// Ports:
//   CC_SPEEDTICKGEN_CLOCK_50     in   system clock, rising edge
//   CC_SPEEDTICKGEN_RESET_InLow  in   synchronous active-low reset
//   tick_bus                     slave modport of cc_speedtickgen_if:
//     enable_InHigh      in   run/pause
//     levelup_InHigh     in   level increment request
//     levelclear_InHigh  in   level clear request (wins over levelup)
//     T0_OutLow          out  registered tick, low for exactly one cycle
//     level_OutBUS       out  current level
//     maxlevel_OutHigh   out  level == MAXLEVEL
//     count_OutBUS       out  current counter value
// -----------------------------------------------------------------------------
module cc_speedtickgen #(
  parameter int unsigned                           SPEEDTICKGEN_DATAWIDTH  = 23,
  parameter int unsigned                           SPEEDTICKGEN_LEVELWIDTH = 3,
  parameter int unsigned                           SPEEDTICKGEN_MAXLEVEL   = 7,
  parameter logic [SPEEDTICKGEN_DATAWIDTH-1:0]     SPEEDTICKGEN_BASE       = 23'h7FFFFF,
  parameter logic [SPEEDTICKGEN_DATAWIDTH-1:0]     SPEEDTICKGEN_STEP       = 23'h0C0000
) (
  input  logic               CC_SPEEDTICKGEN_CLOCK_50,
  input  logic               CC_SPEEDTICKGEN_RESET_InLow,
  cc_speedtickgen_if.slave   tick_bus
);

  localparam int unsigned DW = SPEEDTICKGEN_DATAWIDTH;
  localparam int unsigned LW = SPEEDTICKGEN_LEVELWIDTH;
  localparam int unsigned NUM_LEVEL_CODES = 2 ** LW;
  localparam logic [LW-1:0] MAXLEVEL_L = LW'(SPEEDTICKGEN_MAXLEVEL);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks. The terminal count at the top
  // level must stay >= 1, otherwise the per-level subtraction could wrap.
  // ---------------------------------------------------------------------------
  if (SPEEDTICKGEN_MAXLEVEL > NUM_LEVEL_CODES - 1) begin : g_chk_maxlevel
    $fatal(1, "cc_speedtickgen: MAXLEVEL does not fit in LEVELWIDTH bits");
  end

  if (64'(SPEEDTICKGEN_BASE) <
      (64'(SPEEDTICKGEN_MAXLEVEL) * 64'(SPEEDTICKGEN_STEP)) + 64'd1) begin : g_chk_tc
    $fatal(1, "cc_speedtickgen: BASE - MAXLEVEL*STEP must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Terminal-count table, one constant entry per level code. Codes above
  // MAXLEVEL are unreachable; they repeat the top-level TC so the table is
  // fully defined and never underflows.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] tc_table [NUM_LEVEL_CODES];

  for (genvar gi = 0; gi < NUM_LEVEL_CODES; gi++) begin : g_tc_table
    if (gi <= SPEEDTICKGEN_MAXLEVEL) begin : g_valid
      assign tc_table[gi] = SPEEDTICKGEN_BASE - (DW'(gi) * SPEEDTICKGEN_STEP);
    end else begin : g_unused
      assign tc_table[gi] = SPEEDTICKGEN_BASE - (DW'(SPEEDTICKGEN_MAXLEVEL) * SPEEDTICKGEN_STEP);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0] count_q, count_d;
  logic [LW-1:0] level_q, level_d;
  logic          t0_q,    t0_d;

  logic [DW-1:0] tc;
  logic          at_tc;
  logic          level_change;

  logic enable_i, levelup_i, levelclear_i;
  assign enable_i     = tick_bus.CC_SPEEDTICKGEN_enable_InHigh;
  assign levelup_i    = tick_bus.CC_SPEEDTICKGEN_levelup_InHigh;
  assign levelclear_i = tick_bus.CC_SPEEDTICKGEN_levelclear_InHigh;

  // TC always reflects the current (old) level, so a tick coinciding with a
  // level change is still judged against the period that was running.
  assign tc    = tc_table[level_q];
  assign at_tc = (count_q == tc);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d      = level_q;
    level_change = 1'b0;

    // Clear has priority over levelup. Requests that would not change the
    // level (clear at 0, levelup at max) are not treated as a change, so the
    // counter is left alone in those cases.
    if (levelclear_i) begin
      level_d      = '0;
      level_change = (level_q != '0);
    end else if (levelup_i && (level_q != MAXLEVEL_L)) begin
      level_d      = level_q + LW'(1);
      level_change = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    t0_d    = 1'b1;

    if (enable_i) begin
      if (at_tc) begin
        count_d = '0;
        t0_d    = 1'b0;
      end else begin
        count_d = count_q + DW'(1);
      end
    end

    // A real level change restarts the period regardless of enable, so a
    // shrinking TC can never leave the counter stranded above it. The tick
    // decision above is unaffected.
    if (level_change) begin
      count_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CC_SPEEDTICKGEN_CLOCK_50) begin
    if (!CC_SPEEDTICKGEN_RESET_InLow) begin
      count_q <= '0;
      level_q <= '0;
      t0_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      level_q <= level_d;
      t0_q    <= t0_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tick_bus.CC_SPEEDTICKGEN_T0_OutLow        = t0_q;
  assign tick_bus.CC_SPEEDTICKGEN_level_OutBUS     = level_q;
  assign tick_bus.CC_SPEEDTICKGEN_maxlevel_OutHigh = (level_q == MAXLEVEL_L);
  assign tick_bus.CC_SPEEDTICKGEN_count_OutBUS     = count_q;

endmodule : cc_speedtickgen
